systolic_feeder: RTL
====================

// Module: systolic_feeder
// PURPOSE
//  Upstream stage of the systolic array. On start, streams K packed 32-bit words from the activation SRAM and the weight SRAM.
//  Each word is split into two DATA_WIDTH lanes, and the lanes are driven onto the array's data_1/data_2 and weight_1/weight_2 inputs.
//  Lane 2 is delayed one cycle behind lane 1 to form the systolic diagonal. systolic_en is generated to cover the whole skewed window.
// PARAMETERS
//  DATA_WIDTH       16  width of one lane value (matches array datawith)
//  SRAM_DATA_WIDTH  32  SRAM word width; must equal 2*DATA_WIDTH
//  ADDR_WIDTH       10  SRAM address width
//  LEN_WIDTH        10  width of the vector-count field
// PORTS
//  clk         in   1                clock, rising edge
//  rst         in   1                asynchronous, active-high reset
//  start       in   1                1-cycle request; sampled only in IDLE
//  len         in   LEN_WIDTH        K = number of words to stream (0 allowed)
//  base_a      in   ADDR_WIDTH       first activation SRAM address
//  base_w      in   ADDR_WIDTH       first weight SRAM address
//  sram_ren    out  1                read enable, common to both SRAMs
//  sram_addr_a out  ADDR_WIDTH       activation read address
//  sram_addr_w out  ADDR_WIDTH       weight read address
//  sram_rdata_a in  SRAM_DATA_WIDTH  activation word, valid 1 cycle after ren
//  sram_rdata_w in  SRAM_DATA_WIDTH  weight word, valid 1 cycle after ren
//  data_1      out  DATA_WIDTH       lane-1 activation to array
//  data_2      out  DATA_WIDTH       lane-2 activation to array (skewed +1)
//  weight_1    out  DATA_WIDTH       lane-1 weight to array
//  weight_2    out  DATA_WIDTH       lane-2 weight to array (skewed +1)
//  systolic_en out  1                array enable
//  busy        out  1                transfer in progress
//  done        out  1                1-cycle completion pulse
// BEHAVIOUR
//  - Reset (async, any time, including mid-transfer): all outputs 0, FSM to IDLE, counters cleared; no done pulse after release.
//  - Packing: lane 1 = word[31:16], lane 2 = word[15:0]; no arithmetic; values pass bit-exact.
//  - FSM states: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
//    - IDLE: start=1 latches len/base_a/base_w. Goes to FETCH, or to DONE if len==0.
//    - FETCH: K cycles with sram_ren=1 and addresses base+i, i=0..K-1. No wrap check; addresses wrap mod 2^ADDR_WIDTH.
//    - DRAIN: 3 cycles, flushing the read pipeline and the skew stage.
//    - DONE: done=1 for exactly 1 cycle, then IDLE.
//  - Timing, with start accepted in cycle 0 and K>=1:
//    - address i is issued in cycle 1+i;
//    - lane-1 value of word i appears on data_1/weight_1 in cycle 3+i (registered);
//    - lane-2 value of word i appears on data_2/weight_2 in cycle 4+i;
//    - systolic_en=1 for cycles 3..K+3 (K+1 cycles), contiguous;
//    - done=1 in cycle K+4.
//  - Lane outputs are 0 whenever that lane has no valid word, i.e. lane 2 in cycle 3 and lane 1 in cycle K+3.
//  - len==0: done in cycle 1; sram_ren and systolic_en stay 0.
//  - busy=1 from cycle 1 through the done cycle inclusive; start while busy is ignored (no queueing).
//  - start coinciding with done: ignored; a new start is accepted from the following cycle.
//  - No backpressure: the array consumes every enabled cycle.
// STRUCTURE
//  - Package systolic_pkg: FSM state enum, LANE_HI/LANE_LO slice constants, DRAIN_CYCLES=3, SRAM_RD_LAT=1.
//    Static check that SRAM_DATA_WIDTH==2*DATA_WIDTH.
//  - Sub-module systolic_skew_delay: parametric N-stage register delay line with async reset, carrying value+valid.
//    Instantiated for lane-2 data and weight.
//  - Top level holds the FSM, issue counter, drain counter, and the 2-stage valid pipeline that generates systolic_en.
// TESTING
//  - T1: len=4, base_a=0x010, base_w=0x100, words 0xAAAA0001..0xAAAA0004.
//    -> addr_a 0x010..0x013 in cycles 1-4.
//    -> data_1 = 0xAAAA x4 in cycles 3-6.
//    -> data_2 = 1,2,3,4 in cycles 4-7.
//    -> en high cycles 3-7; done in cycle 8.
//  - T2: len=0 -> done in cycle 1; sram_ren, systolic_en, and all lanes stay 0.
//  - T3: len=1, word 0x12345678 -> data_1=0x1234 in cycle 3, data_2=0x5678 in cycle 4, en high cycles 3-4 only.
//  - T4: start pulsed in cycle 2 of a len=4 transfer -> ignored; exactly one done pulse; addresses unaffected.
//  - T5: rst asserted asynchronously mid-FETCH (cycle 3 of len=8) -> all outputs 0 immediately.
//    -> no done pulse; a fresh start after release behaves as T1.
//  - T6: base_a=0x3FE, len=4 -> addresses 0x3FE,0x3FF,0x000,0x001; data stream unbroken.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feeder.
package systolic_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} state_t;

    // Lane indices into a word viewed as [1:0][DATA_WIDTH-1:0]
    localparam int LANE_HI      = 1;
    localparam int LANE_LO      = 0;
    localparam int DRAIN_CYCLES = 3;
    localparam int SRAM_RD_LAT  = 1;
endpackage

// File: rtl/systolic_skew_delay.sv
// N-stage register delay line carrying value plus valid; value reads 0 when not valid.
module systolic_skew_delay #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_value,
    input  logic             in_valid,
    output logic [WIDTH-1:0] value
);
    logic [STAGES-1:0][WIDTH-1:0] val_q;
    logic [STAGES-1:0]            vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            vld_q <= '0;
        end else begin
            val_q[0] <= in_value;
            vld_q[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) begin
                val_q[s] <= val_q[s-1];
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    assign value = vld_q[STAGES-1] ? val_q[STAGES-1] : '0;
endmodule

// File: rtl/systolic_feeder.sv
// Streams K SRAM words into the systolic array, splitting each into two lanes
// with lane 2 skewed one cycle behind lane 1.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int LEN_WIDTH       = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LEN_WIDTH-1:0]       len,
    input  logic [ADDR_WIDTH-1:0]      base_a,
    input  logic [ADDR_WIDTH-1:0]      base_w,
    output logic                       sram_ren,
    output logic [ADDR_WIDTH-1:0]      sram_addr_a,
    output logic [ADDR_WIDTH-1:0]      sram_addr_w,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata_a,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata_w,
    output logic [DATA_WIDTH-1:0]      data_1,
    output logic [DATA_WIDTH-1:0]      data_2,
    output logic [DATA_WIDTH-1:0]      weight_1,
    output logic [DATA_WIDTH-1:0]      weight_2,
    output logic                       systolic_en,
    output logic                       busy,
    output logic                       done
);
    generate
        if (SRAM_DATA_WIDTH != 2 * DATA_WIDTH) begin : g_width_check
            $error("systolic_feeder: SRAM_DATA_WIDTH must equal 2*DATA_WIDTH");
        end
    endgenerate

    localparam int DRAIN_W     = $clog2(DRAIN_CYCLES);
    localparam int SKEW_STAGES = 2;

    state_t                  state;
    logic [LEN_WIDTH-1:0]    issue_cnt;
    logic [DRAIN_W-1:0]      drain_cnt;
    logic [SRAM_RD_LAT:0]    vld_pipe;
    logic                    rd_vld;

    logic [1:0][DATA_WIDTH-1:0] word_a, word_w;
    logic [1:0][DATA_WIDTH-1:0] lane2_in, lane2_out;

    assign word_a = sram_rdata_a;
    assign word_w = sram_rdata_w;

    // FSM with registered SRAM-side outputs; issue_cnt holds reads still to issue after the current one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            issue_cnt   <= '0;
            drain_cnt   <= '0;
            sram_ren    <= 1'b0;
            sram_addr_a <= '0;
            sram_addr_w <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sram_addr_a <= base_a;
                        sram_addr_w <= base_w;
                        issue_cnt   <= len - LEN_WIDTH'(1);
                        busy        <= 1'b1;
                        if (len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_FETCH;
                            sram_ren <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (issue_cnt == '0) begin
                        state     <= ST_DRAIN;
                        sram_ren  <= 1'b0;
                        drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
                    end else begin
                        issue_cnt   <= issue_cnt - LEN_WIDTH'(1);
                        sram_addr_a <= sram_addr_a + ADDR_WIDTH'(1);
                        sram_addr_w <= sram_addr_w + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // vld_pipe[SRAM_RD_LAT-1] marks read data on the bus; the next stage marks lane-1 output
    assign rd_vld = vld_pipe[SRAM_RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe    <= '0;
            systolic_en <= 1'b0;
            data_1      <= '0;
            weight_1    <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[SRAM_RD_LAT-1:0], sram_ren};
            systolic_en <= vld_pipe[SRAM_RD_LAT-1] | vld_pipe[SRAM_RD_LAT];
            data_1      <= rd_vld ? word_a[LANE_HI] : '0;
            weight_1    <= rd_vld ? word_w[LANE_HI] : '0;
        end
    end

    assign lane2_in[0] = word_a[LANE_LO];
    assign lane2_in[1] = word_w[LANE_LO];

    for (genvar g = 0; g < 2; g++) begin : g_skew
        systolic_skew_delay #(
            .WIDTH (DATA_WIDTH),
            .STAGES(SKEW_STAGES)
        ) u_skew (
            .clk     (clk),
            .rst     (rst),
            .in_value(lane2_in[g]),
            .in_valid(rd_vld),
            .value   (lane2_out[g])
        );
    end

    assign data_2   = lane2_out[0];
    assign weight_2 = lane2_out[1];
endmodule
